// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous, idle-high input.
// All stages preset to 1 so a reset never looks like a falling edge.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the flop chain; preset high on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rxd, validates the start bit, samples
// eight data bits LSB first at mid-bit, checks the stop bit, and holds
// the byte in an output register with a valid/read handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_frame_error,
  output logic       rx_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t state;
  uart_rx_state_t state_next;

  logic                      rxd_s;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      load_pending;

  logic mid_start;
  logic bit_end;
  logic sample_data;
  logic good_stop;
  logic bad_stop;
  logic cnt_clr;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rxd),
    .q    (rxd_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start-bit validation, eight data bits, stop check,
  // and a BREAK state that waits out a held-low line.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (!rxd_s) state_next = START;
      end
      START: begin
        if (mid_start) state_next = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        if (sample_data && (idx == LAST_BIT)) state_next = STOP;
      end
      STOP: begin
        if (bit_end) state_next = rxd_s ? IDLE : BREAK;
      end
      BREAK: begin
        if (rxd_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode: sample strobes and counter clear.
  always_comb begin
    mid_start   = (state == START) && (cnt == HALF_M1);
    bit_end     = (cnt == FULL_M1);
    sample_data = (state == DATA) && bit_end;
    good_stop   = (state == STOP) && bit_end && rxd_s;
    bad_stop    = (state == STOP) && bit_end && !rxd_s;
    cnt_clr     = (state == IDLE) || (state == BREAK) || mid_start || bit_end;
  end

  // Bit-period counter and bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (mid_start) begin
        idx <= '0;
      end else if (sample_data) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Data shift register, filled LSB first at each mid-bit sample.
  always_ff @(posedge clk) begin
    if (sample_data) begin
      shift[idx] <= rxd_s;
    end
  end

  // Stop-bit outcome registered: a load request and the frame-error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_pending   <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      load_pending   <= good_stop;
      rx_frame_error <= bad_stop;
    end
  end

  // Output register with valid/read handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_overrun    <= 1'b0;
    end else if (load_pending) begin
      // A coincident read consumes the old byte, so only an unread byte
      // being overwritten counts as an overrun.
      rx_data       <= shift;
      rx_data_valid <= 1'b1;
      if (rx_data_valid && !rx_read) begin
        rx_overrun <= 1'b1;
      end
    end else if (rx_read && rx_data_valid) begin
      rx_data_valid <= 1'b0;
      rx_overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed/randomized bench for uart_rx at 16 clocks per bit. A serial
// line driver builds 8N1 frames; a byte-level model tracks what the
// consumer should see (data, valid, overrun, frame-error count).
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_frame_error;
  logic       rx_overrun;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int frame_t0 = 0;
  int rise_cyc = 0;
  int vld_rises = 0;
  int fe_cycles = 0;
  logic vld_q = 1'b0;

  // Consumer-visible model state
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .rx_read       (rx_read),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_frame_error(rx_frame_error),
    .rx_overrun    (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: valid rising edges and frame-error high cycles.
  always @(negedge clk) begin
    if (rx_data_valid && !vld_q) begin
      vld_rises = vld_rises + 1;
      rise_cyc  = cyc;
    end
    vld_q = rx_data_valid;
    if (rx_frame_error) fe_cycles = fe_cycles + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"}, int'(rx_data), int'(m_data));
    check({tag, ".valid"}, int'(rx_data_valid), int'(m_valid));
    check({tag, ".overrun"}, int'(rx_overrun), int'(m_ovr));
  endtask

  function automatic void model_load(input logic [7:0] b, input logic read_same_cycle);
    if (m_valid && !read_same_cycle) m_ovr = 1'b1;
    m_data  = b;
    m_valid = 1'b1;
  endfunction

  function automatic void model_read();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endfunction

  // Drive one 8N1 frame, one bit per CPB cycles. rx_read is pulsed at
  // cycle read_at of the frame; reset is pulsed at cycle abort_at and the
  // frame is abandoned (negative values disable either).
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int read_at, input int abort_at);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int n = 0; n < 10 * CPB; n++) begin
      @(negedge clk);
      if (n == 0) frame_t0 = cyc;
      if (n == abort_at) begin
        reset   = 1'b1;
        rx_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rxd   = 1'b1;
        break;
      end
      rxd     = fr[n/CPB];
      rx_read = (n == read_at);
    end
    rx_read = 1'b0;
  endtask

  task automatic do_read();
    @(negedge clk);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] hi [4];
    logic [7:0] b;
    int         fe0;
    int         rises0;
    int         lat;
    int         rd;

    hi = '{8'h48, 8'h69, 8'h0D, 8'h0A};

    reset   = 1'b1;
    rxd     = 1'b1;
    rx_read = 1'b0;
    model_reset();
    idle(4);
    reset = 1'b0;
    idle(2);
    check_model("reset");
    check("reset.frame_error", int'(rx_frame_error), 0);

    // Single frame 0x55: value, latency, single valid rise
    rises0 = vld_rises;
    send_frame(8'h55, 1'b1, -1, -1);
    model_load(8'h55, 1'b0);
    check_model("f55");
    lat = rise_cyc - frame_t0 - 1;
    check("f55.latency_in_range", int'(lat >= 154 && lat <= 156), 1);
    check("f55.valid_rises", vld_rises - rises0, 1);
    do_read();
    model_read();
    check_model("f55.read");

    // "Hi\r\n", reading each byte once it is valid
    for (int i = 0; i < 4; i++) begin
      send_frame(hi[i], 1'b1, -1, -1);
      model_load(hi[i], 1'b0);
      check_model($sformatf("hi%0d", i));
      do_read();
      model_read();
    end
    check("hi.frame_errors", fe_cycles, 0);

    // Start-bit glitch: 5 low cycles, then a real frame
    @(negedge clk);
    rxd = 1'b0;
    idle(5);
    rxd = 1'b1;
    idle(40);
    check_model("glitch");
    check("glitch.frame_errors", fe_cycles, 0);
    send_frame(8'hA3, 1'b1, -1, -1);
    model_load(8'hA3, 1'b0);
    check_model("glitch.fa3");
    do_read();
    model_read();

    // Bad stop bit with line held low: exactly one error pulse
    fe0 = fe_cycles;
    send_frame(8'h3C, 1'b0, -1, -1);
    idle(40);
    check("break.frame_error_pulses", fe_cycles - fe0, 1);
    check_model("break");
    rxd = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, -1, -1);
    model_load(8'h81, 1'b0);
    check_model("break.f81");
    check("break.no_more_errors", fe_cycles - fe0, 1);
    do_read();
    model_read();

    // Overrun: two frames back to back, nothing read
    send_frame(8'h11, 1'b1, -1, -1);
    model_load(8'h11, 1'b0);
    send_frame(8'h22, 1'b1, -1, -1);
    model_load(8'h22, 1'b0);
    check_model("ovr");
    do_read();
    model_read();
    check_model("ovr.read");

    // Read coincident with the second load: no overrun
    send_frame(8'h11, 1'b1, -1, -1);
    model_load(8'h11, 1'b0);
    send_frame(8'h22, 1'b1, 155, -1);
    model_load(8'h22, 1'b1);
    check_model("ovr_coincident");
    do_read();
    model_read();
    check_model("ovr_coincident.read");

    // Random bytes with random consumer behaviour
    for (int i = 0; i < 8; i++) begin
      b  = 8'($urandom_range(0, 255));
      rd = int'($urandom_range(0, 1));
      send_frame(b, 1'b1, -1, -1);
      model_load(b, 1'b0);
      check_model($sformatf("rnd%0d", i));
      if (rd != 0) begin
        do_read();
        model_read();
        check_model($sformatf("rnd%0d.read", i));
      end
    end

    // Reset during data bit 4 of 0xF0, with an unread byte pending
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, -1, -1);
    model_load(b, 1'b0);
    check_model("prereset");
    send_frame(8'hF0, 1'b1, -1, 5 * CPB + CPB / 2);
    model_reset();
    check_model("midreset");
    check("midreset.frame_error", int'(rx_frame_error), 0);
    idle(12 * CPB);
    check_model("midreset.no_partial");
    send_frame(8'h0F, 1'b1, -1, -1);
    model_load(8'h0F, 1'b0);
    check_model("postreset.f0f");
    check("final.frame_errors", fe_cycles - fe0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver, the receive-side counterpart of uart_tx, running at the same bit rate. It synchronizes the asynchronous UART_RXD pin, detects and validates the start bit, samples 8 data bits (LSB first) at mid-bit, and checks the stop bit. Each received byte is held in an output register for the consumer (CPU MMIO read port or FIFO) with a valid/read handshake. Framing errors and overruns are flagged.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); must be >= 4; must match uart_tx.
SYNC_STAGES, 2, flops in the rxd input synchronizer; must be >= 2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rxd  input  1  asynchronous serial input, idle high
rx_read  input  1  consumer takes rx_data this cycle; ignored when rx_data_valid=0
rx_data  output  8  last received byte
rx_data_valid  output  1  rx_data holds an unread byte
rx_frame_error  output  1  one-cycle pulse: stop bit sampled low
rx_overrun  output  1  sticky: a byte completed while the previous one was unread

Behaviour:
- Reset: rx_data=0, rx_data_valid=0, rx_frame_error=0, rx_overrun=0, state=IDLE, counters=0, synchronizer flops=1. Reset mid-frame aborts the frame; no partial byte is ever delivered.
- Synchronizer: SYNC_STAGES flops preset to 1; the FSM sees only rxd_s, the last stage.
- Bit counter: width $clog2(CLKS_PER_BIT); bit index 0..7.
- IDLE: on rxd_s==0, go to START and clear the counter.
- START: when counter==CLKS_PER_BIT/2-1 (mid start bit), sample rxd_s. If 0, go to DATA with counter=0 and bit index=0. If 1, treat as a glitch and return to IDLE with no flags.
- DATA: when counter==CLKS_PER_BIT-1, sample rxd_s into shift[index] (LSB first) and reset the counter. After index 7, go to STOP.
- STOP: when counter==CLKS_PER_BIT-1, sample rxd_s.
  - If 1 (good frame), load the output register and return to IDLE.
  - If 0, pulse rx_frame_error for one cycle, discard the byte and go to BREAK.
- BREAK: wait for rxd_s==1, then go to IDLE. A held-low line produces exactly one frame_error.
- Output register, updated on the cycle after a good stop sample:
  - rx_data <= shift, rx_data_valid <= 1.
  - If rx_data_valid==1 and rx_read==0 that cycle, set rx_overrun and overwrite rx_data with the new byte.
  - If rx_read==1 in the same cycle as a load, the old byte is consumed, the new byte is loaded, valid stays 1 and overrun is not set.
- rx_read with valid=1 and no load: valid <= 0 next cycle, and rx_overrun is cleared on that cycle.
- Latency: valid rises SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the rxd falling edge.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so the next start edge is detected with no dead time.
- Tolerance: mid-bit sampling accepts up to ±4% total baud mismatch.

Decomposition:
- uart_pkg (shared with uart_tx):
  - UART_DATA_BITS=8
  - DEFAULT_CLKS_PER_BIT=434
  - typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, STOP, BREAK}
- Sub-module sync_ff #(STAGES) for the input synchronizer, reusable for KEY inputs. The FSM and output register stay in uart_rx.

Test Plan:
(All scenarios use CLKS_PER_BIT=16 and drive rxd at 16 cycles/bit unless stated.)
- Frame 0x55, stop=1 -> rx_data=0x55, valid rises once at expected latency ±1, no flags; rx_read -> valid=0 next cycle.
- Loopback uart_tx->uart_rx sending "Hi\r\n" with rx_read pulsed on each valid -> bytes 0x48, 0x69, 0x0D, 0x0A in order, no flags.
- rxd low for 5 cycles then high (glitch) -> state back to IDLE, valid stays 0, no flags; a following 0xA3 frame is received correctly.
- Frame 0x3C with stop bit 0, line held low 40 cycles -> single one-cycle frame_error pulse, valid=0; after line returns high, a 0x81 frame is received.
- 0x11 then 0x22 sent with no rx_read -> rx_data=0x22, valid=1, overrun=1; rx_read -> valid=0, overrun=0. Repeat with rx_read coincident with the second load -> no overrun.
- reset asserted during data bit 4 of 0xF0 -> all outputs 0 next cycle; after release, a 0x0F frame is received correctly.
